cu_fsm_mc: RTL and testbench

- Multicycle control unit for the RV32I core, next generation of the current control FSM.
- Adds wait-state handshakes on the instruction and data memories, a bus-timeout watchdog, optional multicycle M-extension sequencing, interrupt-enable gating and an illegal-instruction/bus-error trap path.
- Sits between the IR decode fields and the PC, RegFile, Memory, CSR and MulDiv units.
- With imem_ready=dmem_ready=1 and M_EXT=0, legal-instruction cycle counts match the previous FSM.

---
 rtl/cu_pkg.sv | 33 +++
 rtl/cu_timeout_ctr.sv | 39 +++
 rtl/cu_fsm_mc.sv | 195 +++++++++++++++++++
 tb/tb_cu_fsm_mc.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared states, opcodes and trap causes for the multicycle control unit
package cu_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_FETCH,
    ST_EXEC,
    ST_MEM_WAIT,
    ST_WRITEBACK,
    ST_MD_WAIT,
    ST_INTR,
    ST_TRAP
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

  typedef enum logic [1:0] {
    CAUSE_ILLEGAL  = 2'b00,
    CAUSE_FETCH_TO = 2'b01,
    CAUSE_DATA_TO  = 2'b10,
    CAUSE_RSVD     = 2'b11
  } cause_t;

endpackage

// File: rtl/cu_timeout_ctr.sv
// rtl/cu_timeout_ctr.sv - bus wait watchdog; expired flags the last tolerated not-ready cycle
module cu_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  input  logic ready,
  output logic expired
);

  // A zero-cycle limit still needs a legal one-bit counter
  localparam int CW = (TO_W < 1) ? 1 : TO_W;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run && !ready && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (TIMEOUT_CYCLES != 0) && run && !ready && (cnt_q == LIMIT);

endmodule

// File: rtl/cu_fsm_mc.sv
// rtl/cu_fsm_mc.sv - RV32I multicycle control FSM with memory wait states, watchdog, MulDiv and trap paths
module cu_fsm_mc
  import cu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1),
  parameter int M_EXT          = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_0,
  input  logic       intr,
  input  logic       mie,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  input  logic       md_done,
  output logic       PC_WE,
  output logic       RF_WE,
  output logic       mem_WE2,
  output logic       memRDEN1,
  output logic       memRDEN2,
  output logic       reset,
  output logic       csr_WE,
  output logic       int_taken,
  output logic       mret_exec,
  output logic       md_start,
  output logic       exc_taken,
  output logic [1:0] exc_cause
);

  state_t state_q, state_d, done_ns;
  cause_t cause_q, cause_d;
  logic   to_run, to_ready, to_clear, to_expired, is_store;

  assign done_ns  = (intr && mie) ? ST_INTR : ST_FETCH;
  assign is_store = (opcode == OP_STORE);
  assign to_run   = (state_q == ST_FETCH) || (state_q == ST_MEM_WAIT);
  assign to_ready = (state_q == ST_FETCH) ? imem_ready : dmem_ready;
  assign to_clear = ((state_d == ST_FETCH) && (state_q != ST_FETCH)) ||
                    ((state_d == ST_MEM_WAIT) && (state_q != ST_MEM_WAIT));

  cu_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_to (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (to_clear),
    .run    (to_run),
    .ready  (to_ready),
    .expired(to_expired)
  );

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    PC_WE     = 1'b0;
    RF_WE     = 1'b0;
    mem_WE2   = 1'b0;
    memRDEN1  = 1'b0;
    memRDEN2  = 1'b0;
    reset     = 1'b0;
    csr_WE    = 1'b0;
    int_taken = 1'b0;
    mret_exec = 1'b0;
    md_start  = 1'b0;
    exc_taken = 1'b0;
    case (state_q)
      ST_INIT: begin
        reset   = 1'b1;
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        memRDEN1 = 1'b1;
        if (imem_ready) begin
          state_d = ST_EXEC;
        end else if (to_expired) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_FETCH_TO;
        end
      end
      ST_EXEC: begin
        case (opcode)
          OP_R: begin
            if (!funct7_0) begin
              PC_WE   = 1'b1;
              RF_WE   = 1'b1;
              state_d = done_ns;
            end else if (M_EXT != 0) begin
              md_start = 1'b1;
              state_d  = ST_MD_WAIT;
            end else begin
              state_d = ST_TRAP;
              cause_d = CAUSE_ILLEGAL;
            end
          end
          OP_I, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: begin
            PC_WE   = 1'b1;
            RF_WE   = 1'b1;
            state_d = done_ns;
          end
          OP_BRANCH: begin
            PC_WE   = 1'b1;
            state_d = done_ns;
          end
          OP_SYS: begin
            case (funct3)
              3'b000: begin
                PC_WE     = 1'b1;
                mret_exec = 1'b1;
                state_d   = done_ns;
              end
              3'b100: begin
                state_d = ST_TRAP;
                cause_d = CAUSE_ILLEGAL;
              end
              default: begin
                PC_WE   = 1'b1;
                RF_WE   = 1'b1;
                csr_WE  = 1'b1;
                state_d = done_ns;
              end
            endcase
          end
          OP_LOAD: begin
            memRDEN2 = 1'b1;
            state_d  = dmem_ready ? ST_WRITEBACK : ST_MEM_WAIT;
          end
          OP_STORE: begin
            mem_WE2 = 1'b1;
            if (dmem_ready) begin
              PC_WE   = 1'b1;
              state_d = done_ns;
            end else begin
              state_d = ST_MEM_WAIT;
            end
          end
          default: begin
            state_d = ST_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      ST_MEM_WAIT: begin
        mem_WE2  = is_store;
        memRDEN2 = !is_store;
        if (dmem_ready) begin
          PC_WE   = is_store;
          state_d = is_store ? done_ns : ST_WRITEBACK;
        end else if (to_expired) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_DATA_TO;
        end
      end
      ST_WRITEBACK: begin
        PC_WE   = 1'b1;
        RF_WE   = 1'b1;
        state_d = done_ns;
      end
      ST_MD_WAIT: begin
        if (md_done) begin
          PC_WE   = 1'b1;
          RF_WE   = 1'b1;
          state_d = done_ns;
        end
      end
      ST_INTR: begin
        PC_WE     = 1'b1;
        int_taken = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_TRAP: begin
        PC_WE     = 1'b1;
        exc_taken = 1'b1;
        state_d   = ST_FETCH;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cause_q <= CAUSE_ILLEGAL;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  assign exc_cause = cause_q;

endmodule

// File: tb/tb_cu_fsm_mc.sv
// tb/tb_cu_fsm_mc.sv - directed cycle-by-cycle check of cu_fsm_mc strobes and trap causes
module tb_cu_fsm_mc;

  // Strobe vector order: PC_WE RF_WE mem_WE2 memRDEN1 memRDEN2 reset csr_WE int_taken mret_exec md_start exc_taken
  localparam logic [10:0] O_NONE  = 11'h000;
  localparam logic [10:0] O_INIT  = 11'h020;
  localparam logic [10:0] O_FETCH = 11'h080;
  localparam logic [10:0] O_ALU   = 11'h600;
  localparam logic [10:0] O_LD    = 11'h040;
  localparam logic [10:0] O_ST    = 11'h100;
  localparam logic [10:0] O_STD   = 11'h500;
  localparam logic [10:0] O_TRAP  = 11'h401;
  localparam logic [10:0] O_INTR  = 11'h408;
  localparam logic [10:0] O_MDS   = 11'h002;
  localparam logic [10:0] O_CSR   = 11'h610;
  localparam logic [10:0] O_MRET  = 11'h404;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  logic clk, rst_n, rst0_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic funct7_0, intr, mie, imem_ready, dmem_ready, md_done;
  logic PC_WE, RF_WE, mem_WE2, memRDEN1, memRDEN2, reset, csr_WE, int_taken, mret_exec, md_start, exc_taken;
  logic [1:0] exc_cause;
  logic PC_WE0, RF_WE0, mem_WE20, memRDEN10, memRDEN20, reset0, csr_WE0, int_taken0, mret_exec0, md_start0, exc_taken0;
  logic [1:0] exc_cause0;
  logic [10:0] outs, outs0;
  int n_tests = 0;
  int n_fail  = 0;

  assign outs  = {PC_WE, RF_WE, mem_WE2, memRDEN1, memRDEN2, reset, csr_WE, int_taken, mret_exec, md_start, exc_taken};
  assign outs0 = {PC_WE0, RF_WE0, mem_WE20, memRDEN10, memRDEN20, reset0, csr_WE0, int_taken0, mret_exec0, md_start0, exc_taken0};

  cu_fsm_mc #(.TIMEOUT_CYCLES(8), .TO_W(4), .M_EXT(1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_0(funct7_0),
    .intr(intr), .mie(mie), .imem_ready(imem_ready), .dmem_ready(dmem_ready), .md_done(md_done),
    .PC_WE(PC_WE), .RF_WE(RF_WE), .mem_WE2(mem_WE2), .memRDEN1(memRDEN1), .memRDEN2(memRDEN2),
    .reset(reset), .csr_WE(csr_WE), .int_taken(int_taken), .mret_exec(mret_exec),
    .md_start(md_start), .exc_taken(exc_taken), .exc_cause(exc_cause)
  );

  cu_fsm_mc #(.TIMEOUT_CYCLES(8), .TO_W(4), .M_EXT(0)) dut0 (
    .clk(clk), .rst_n(rst0_n), .opcode(opcode), .funct3(funct3), .funct7_0(funct7_0),
    .intr(intr), .mie(mie), .imem_ready(imem_ready), .dmem_ready(dmem_ready), .md_done(md_done),
    .PC_WE(PC_WE0), .RF_WE(RF_WE0), .mem_WE2(mem_WE20), .memRDEN1(memRDEN10), .memRDEN2(memRDEN20),
    .reset(reset0), .csr_WE(csr_WE0), .int_taken(int_taken0), .mret_exec(mret_exec0),
    .md_start(md_start0), .exc_taken(exc_taken0), .exc_cause(exc_cause0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Entered 1 time unit after a rising edge; samples mid-cycle, then moves to the next cycle
  task automatic exp_cyc(input string tag, input logic [10:0] e);
    #1;
    check(tag, {21'b0, outs}, {21'b0, e});
    @(posedge clk);
    #1;
  endtask

  task automatic exp_cyc0(input string tag, input logic [10:0] e);
    #1;
    check(tag, {21'b0, outs0}, {21'b0, e});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; rst0_n = 1'b0;
    opcode = OP_I; funct3 = 3'b000; funct7_0 = 1'b0;
    intr = 1'b0; mie = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1; md_done = 1'b0;
    #1;
    check("rst_outs", {21'b0, outs}, {21'b0, O_INIT});
    check("rst_cause", {30'b0, exc_cause}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    exp_cyc("init", O_INIT);

    exp_cyc("addi_fetch", O_FETCH);
    exp_cyc("addi_exec", O_ALU);
    opcode = OP_LOAD;
    exp_cyc("lw_fetch", O_FETCH);
    exp_cyc("lw_exec", O_LD);
    exp_cyc("lw_wb", O_ALU);

    opcode = OP_STORE;
    exp_cyc("sw_fetch", O_FETCH);
    dmem_ready = 1'b0;
    exp_cyc("sw_exec", O_ST);
    for (int i = 0; i < 3; i++) exp_cyc("sw_wait", O_ST);
    dmem_ready = 1'b1;
    exp_cyc("sw_done", O_STD);

    opcode = OP_I; imem_ready = 1'b0;
    for (int i = 0; i < 8; i++) exp_cyc("fto_fetch", O_FETCH);
    imem_ready = 1'b1;
    exp_cyc("fto_trap", O_TRAP);
    check("fto_cause", {30'b0, exc_cause}, 32'd1);
    exp_cyc("fto_refetch", O_FETCH);
    exp_cyc("fto_exec", O_ALU);

    imem_ready = 1'b0;
    for (int i = 0; i < 7; i++) exp_cyc("edge_fetch", O_FETCH);
    imem_ready = 1'b1;
    exp_cyc("edge_ready", O_FETCH);
    exp_cyc("edge_exec", O_ALU);

    opcode = OP_R; funct7_0 = 1'b1;
    exp_cyc("mul_fetch", O_FETCH);
    md_done = 1'b1;
    exp_cyc("mul_exec", O_MDS);
    md_done = 1'b0;
    for (int i = 0; i < 5; i++) exp_cyc("md_wait", O_NONE);
    md_done = 1'b1;
    exp_cyc("md_done", O_ALU);
    md_done = 1'b0; funct7_0 = 1'b0;

    intr = 1'b1; mie = 1'b0;
    exp_cyc("add_fetch", O_FETCH);
    exp_cyc("add_exec", O_ALU);
    mie = 1'b1;
    exp_cyc("noirq_fetch", O_FETCH);
    exp_cyc("irq_exec", O_ALU);
    exp_cyc("intr", O_INTR);
    opcode = 7'b0000000;
    exp_cyc("ill_fetch", O_FETCH);
    exp_cyc("ill_exec", O_NONE);
    exp_cyc("ill_trap", O_TRAP);
    check("ill_cause", {30'b0, exc_cause}, 32'd0);
    intr = 1'b0; mie = 1'b0;

    opcode = OP_SYS; funct3 = 3'b100;
    exp_cyc("csr100_fetch", O_FETCH);
    exp_cyc("csr100_exec", O_NONE);
    exp_cyc("csr100_trap", O_TRAP);
    funct3 = 3'b001;
    exp_cyc("csrrw_fetch", O_FETCH);
    exp_cyc("csrrw_exec", O_CSR);
    funct3 = 3'b000;
    exp_cyc("mret_fetch", O_FETCH);
    exp_cyc("mret_exec", O_MRET);

    opcode = OP_LOAD; dmem_ready = 1'b0;
    exp_cyc("dto_fetch", O_FETCH);
    exp_cyc("dto_exec", O_LD);
    for (int i = 0; i < 8; i++) exp_cyc("dto_wait", O_LD);
    exp_cyc("dto_trap", O_TRAP);
    check("dto_cause", {30'b0, exc_cause}, 32'd2);

    exp_cyc("ar_fetch", O_FETCH);
    exp_cyc("ar_exec", O_LD);
    exp_cyc("ar_wait", O_LD);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_outs", {21'b0, outs}, {21'b0, O_INIT});
    check("ar_cause", {30'b0, exc_cause}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dmem_ready = 1'b1; opcode = OP_I; imem_ready = 1'b0;
    exp_cyc("ar_init", O_INIT);
    for (int i = 0; i < 7; i++) exp_cyc("ar_refetch", O_FETCH);
    imem_ready = 1'b1;
    exp_cyc("ar_fetch_ok", O_FETCH);
    exp_cyc("ar_exec_ok", O_ALU);

    rst0_n = 1'b1;
    opcode = OP_R; funct7_0 = 1'b1;
    exp_cyc0("m0_init", O_INIT);
    exp_cyc0("m0_fetch", O_FETCH);
    exp_cyc0("m0_exec", O_NONE);
    exp_cyc0("m0_trap", O_TRAP);
    check("m0_cause", {30'b0, exc_cause0}, 32'd0);
    funct7_0 = 1'b0;
    exp_cyc0("m0_refetch", O_FETCH);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
